// File: rtl/bcd_updn_cnt.sv
// Multi-digit BCD up/down counter with programmable terminal value, synchronous load
// and wrap/saturate behaviour at both ends. Digit 0 occupies cnt[3:0].
module bcd_updn_cnt #(
    parameter int unsigned         DIGITS   = 2,
    parameter logic [4*DIGITS-1:0] LIMIT    = {DIGITS{4'h9}},
    parameter bit                  SATURATE = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   cnt,
    output logic                  tc,
    output logic                  ovf,
    output logic                  load_err
);

    localparam int unsigned W = 4 * DIGITS;

    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] cnt_inc, cnt_dec;
    logic         ovf_q, ovf_d;
    logic         err_q, err_d;
    logic         at_limit, at_zero;
    logic         nib_ok, le_limit, load_ok;

    assign at_limit = (cnt_q == LIMIT);
    assign at_zero  = (cnt_q == '0);

    // Per-digit increment with a ripple carry; a digit at 9 rolls to 0.
    always_comb begin
        logic carry;
        carry   = 1'b1;
        cnt_inc = cnt_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (carry) begin
                if (cnt_q[4*i +: 4] == 4'd9) begin
                    cnt_inc[4*i +: 4] = 4'd0;
                end else begin
                    cnt_inc[4*i +: 4] = cnt_q[4*i +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
    end

    // Per-digit decrement with a ripple borrow; a digit at 0 rolls to 9.
    always_comb begin
        logic borrow;
        borrow  = 1'b1;
        cnt_dec = cnt_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (borrow) begin
                if (cnt_q[4*i +: 4] == 4'd0) begin
                    cnt_dec[4*i +: 4] = 4'd9;
                end else begin
                    cnt_dec[4*i +: 4] = cnt_q[4*i +: 4] - 4'd1;
                    borrow            = 1'b0;
                end
            end
        end
    end

    // Load is accepted only for a well-formed BCD value not above LIMIT.
    // The magnitude compare walks digits from the most significant end.
    always_comb begin
        logic decided;
        nib_ok   = 1'b1;
        le_limit = 1'b1;
        decided  = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (load_val[4*i +: 4] > 4'd9) begin
                nib_ok = 1'b0;
            end
        end
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            if (!decided && (load_val[4*i +: 4] != LIMIT[4*i +: 4])) begin
                decided  = 1'b1;
                le_limit = (load_val[4*i +: 4] < LIMIT[4*i +: 4]);
            end
        end
        load_ok = nib_ok && le_limit;
    end

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = 1'b0;
        err_d = 1'b0;
        if (load) begin
            if (load_ok) begin
                cnt_d = load_val;
            end else begin
                err_d = 1'b1;
            end
        end else if (en) begin
            if (up) begin
                if (!at_limit) begin
                    cnt_d = cnt_inc;
                end else if (!SATURATE) begin
                    cnt_d = '0;
                    ovf_d = 1'b1;
                end
            end else begin
                if (!at_zero) begin
                    cnt_d = cnt_dec;
                end else if (!SATURATE) begin
                    cnt_d = LIMIT;
                    ovf_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            err_q <= err_d;
        end
    end

    assign cnt      = cnt_q;
    assign ovf      = ovf_q;
    assign load_err = err_q;
    // Combinational so a cascaded higher stage can step in the same cycle.
    assign tc       = up ? at_limit : at_zero;

endmodule

// File: tb/tb_bcd_updn_cnt.sv
// Directed bench for bcd_updn_cnt: wrap, saturate, 3-digit and a seconds/minutes cascade.
module tb_bcd_updn_cnt;

    logic clk, rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Two-digit wrap instance, LIMIT 59
    logic w_en, w_up, w_load, w_tc, w_ovf, w_err;
    logic [7:0] w_val, w_cnt;
    // Two-digit saturate instance, LIMIT 59
    logic s_en, s_up, s_load, s_tc, s_ovf, s_err;
    logic [7:0] s_val, s_cnt;
    // Three-digit instance, default LIMIT 999
    logic t_en, t_up, t_load, t_tc, t_ovf, t_err;
    logic [11:0] t_val, t_cnt;
    // Seconds/minutes cascade
    logic c_en, c_up, c_load, c_men;
    logic c_stc, c_mtc, c_sovf, c_movf, c_serr, c_merr;
    logic [7:0] c_sval, c_mval, c_scnt, c_mcnt;

    assign c_men = c_en && c_stc;

    bcd_updn_cnt #(.DIGITS(2), .LIMIT(8'h59), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .en(w_en), .up(w_up), .load(w_load), .load_val(w_val),
        .cnt(w_cnt), .tc(w_tc), .ovf(w_ovf), .load_err(w_err));

    bcd_updn_cnt #(.DIGITS(2), .LIMIT(8'h59), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst(rst), .en(s_en), .up(s_up), .load(s_load), .load_val(s_val),
        .cnt(s_cnt), .tc(s_tc), .ovf(s_ovf), .load_err(s_err));

    bcd_updn_cnt #(.DIGITS(3)) u_three (
        .clk(clk), .rst(rst), .en(t_en), .up(t_up), .load(t_load), .load_val(t_val),
        .cnt(t_cnt), .tc(t_tc), .ovf(t_ovf), .load_err(t_err));

    bcd_updn_cnt #(.DIGITS(2), .LIMIT(8'h59), .SATURATE(1'b0)) u_sec (
        .clk(clk), .rst(rst), .en(c_en), .up(c_up), .load(c_load), .load_val(c_sval),
        .cnt(c_scnt), .tc(c_stc), .ovf(c_sovf), .load_err(c_serr));

    bcd_updn_cnt #(.DIGITS(2), .LIMIT(8'h59), .SATURATE(1'b0)) u_min (
        .clk(clk), .rst(rst), .en(c_men), .up(c_up), .load(c_load), .load_val(c_mval),
        .cnt(c_mcnt), .tc(c_mtc), .ovf(c_movf), .load_err(c_merr));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_checks++; if (w_cnt !== 8'h00) begin n_fail++; $display("FAIL reset_cnt: got %h want 00", w_cnt); end
        n_checks++; if (w_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", w_ovf); end
        n_checks++; if (w_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", w_err); end
        n_checks++; if (w_tc !== 1'b1) begin n_fail++; $display("FAIL reset_tc_down: got %b want 1", w_tc); end
        n_checks++; if (t_cnt !== 12'h000) begin n_fail++; $display("FAIL reset_cnt3: got %h want 000", t_cnt); end
        rst = 1'b1;
    endtask

    task automatic test_reset_mid_count();
        w_up = 1'b1; w_load = 1'b1; w_val = 8'h30;
        step();
        w_load = 1'b0; w_en = 1'b1;
        repeat (7) step();
        n_checks++; if (w_cnt !== 8'h37) begin n_fail++; $display("FAIL mid_count37: got %h want 37", w_cnt); end
        w_en = 1'b0;
        #2; rst = 1'b0; #1;
        n_checks++; if (w_cnt !== 8'h00) begin n_fail++; $display("FAIL mid_reset_cnt: got %h want 00", w_cnt); end
        n_checks++; if (w_ovf !== 1'b0) begin n_fail++; $display("FAIL mid_reset_ovf: got %b want 0", w_ovf); end
        #1; rst = 1'b1; w_en = 1'b1;
        step();
        n_checks++; if (w_cnt !== 8'h01) begin n_fail++; $display("FAIL post_reset_inc: got %h want 01", w_cnt); end
        w_en = 1'b0;
    endtask

    task automatic test_carry_wrap();
        w_up = 1'b1; w_load = 1'b1; w_val = 8'h58;
        step();
        w_load = 1'b0;
        n_checks++; if (w_cnt !== 8'h58) begin n_fail++; $display("FAIL load58: got %h want 58", w_cnt); end
        n_checks++; if (w_tc !== 1'b0) begin n_fail++; $display("FAIL tc58: got %b want 0", w_tc); end
        w_en = 1'b1;
        step();
        n_checks++; if (w_cnt !== 8'h59) begin n_fail++; $display("FAIL up59: got %h want 59", w_cnt); end
        n_checks++; if (w_tc !== 1'b1) begin n_fail++; $display("FAIL tc59: got %b want 1", w_tc); end
        n_checks++; if (w_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf59: got %b want 0", w_ovf); end
        step();
        n_checks++; if (w_cnt !== 8'h00) begin n_fail++; $display("FAIL wrap00: got %h want 00", w_cnt); end
        n_checks++; if (w_ovf !== 1'b1) begin n_fail++; $display("FAIL wrap_ovf: got %b want 1", w_ovf); end
        step();
        n_checks++; if (w_cnt !== 8'h01) begin n_fail++; $display("FAIL after_wrap01: got %h want 01", w_cnt); end
        n_checks++; if (w_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_one_cycle: got %b want 0", w_ovf); end
        w_load = 1'b1; w_val = 8'h08;
        step();
        w_load = 1'b0;
        step();
        n_checks++; if (w_cnt !== 8'h09) begin n_fail++; $display("FAIL up09: got %h want 09", w_cnt); end
        step();
        n_checks++; if (w_cnt !== 8'h10) begin n_fail++; $display("FAIL carry10: got %h want 10", w_cnt); end
        w_en = 1'b0;
    endtask

    task automatic test_down_borrow();
        logic [7:0] exp_v;
        w_up = 1'b0; w_load = 1'b1; w_val = 8'h10;
        step();
        w_load = 1'b0; w_en = 1'b1;
        for (int k = 9; k >= 0; k--) begin
            step();
            exp_v = {4'h0, 4'(k)};
            n_checks++; if (w_cnt !== exp_v) begin n_fail++; $display("FAIL down_seq: got %h want %h", w_cnt, exp_v); end
        end
        n_checks++; if (w_tc !== 1'b1) begin n_fail++; $display("FAIL tc_down00: got %b want 1", w_tc); end
        step();
        n_checks++; if (w_cnt !== 8'h59) begin n_fail++; $display("FAIL down_wrap59: got %h want 59", w_cnt); end
        n_checks++; if (w_ovf !== 1'b1) begin n_fail++; $display("FAIL down_wrap_ovf: got %b want 1", w_ovf); end
        n_checks++; if (w_tc !== 1'b0) begin n_fail++; $display("FAIL tc_down59: got %b want 0", w_tc); end
        step();
        n_checks++; if (w_cnt !== 8'h58) begin n_fail++; $display("FAIL down58: got %h want 58", w_cnt); end
        n_checks++; if (w_ovf !== 1'b0) begin n_fail++; $display("FAIL down_ovf_clear: got %b want 0", w_ovf); end
        w_en = 1'b0;
    endtask

    task automatic test_saturate();
        s_up = 1'b1; s_load = 1'b1; s_val = 8'h59;
        step();
        s_load = 1'b0; s_en = 1'b1;
        n_checks++; if (s_tc !== 1'b1) begin n_fail++; $display("FAIL sat_tc: got %b want 1", s_tc); end
        repeat (2) begin
            step();
            n_checks++; if (s_cnt !== 8'h59) begin n_fail++; $display("FAIL sat_hold59: got %h want 59", s_cnt); end
            n_checks++; if (s_ovf !== 1'b0) begin n_fail++; $display("FAIL sat_ovf_hi: got %b want 0", s_ovf); end
        end
        s_en = 1'b0; s_load = 1'b1; s_val = 8'h00;
        step();
        s_load = 1'b0; s_up = 1'b0; s_en = 1'b1;
        step();
        n_checks++; if (s_cnt !== 8'h00) begin n_fail++; $display("FAIL sat_hold00: got %h want 00", s_cnt); end
        n_checks++; if (s_ovf !== 1'b0) begin n_fail++; $display("FAIL sat_ovf_lo: got %b want 0", s_ovf); end
        s_up = 1'b1;
        step();
        n_checks++; if (s_cnt !== 8'h01) begin n_fail++; $display("FAIL sat_up01: got %h want 01", s_cnt); end
        s_en = 1'b0;
    endtask

    task automatic test_load();
        w_up = 1'b1; w_en = 1'b1; w_load = 1'b1; w_val = 8'h42;
        step();
        n_checks++; if (w_cnt !== 8'h42) begin n_fail++; $display("FAIL load_prio: got %h want 42", w_cnt); end
        n_checks++; if (w_err !== 1'b0) begin n_fail++; $display("FAIL load_ok_err: got %b want 0", w_err); end
        w_val = 8'h4A;
        step();
        n_checks++; if (w_cnt !== 8'h42) begin n_fail++; $display("FAIL bad_nib_hold: got %h want 42", w_cnt); end
        n_checks++; if (w_err !== 1'b1) begin n_fail++; $display("FAIL bad_nib_err: got %b want 1", w_err); end
        n_checks++; if (w_ovf !== 1'b0) begin n_fail++; $display("FAIL bad_nib_ovf: got %b want 0", w_ovf); end
        w_load = 1'b0; w_en = 1'b0;
        step();
        n_checks++; if (w_err !== 1'b0) begin n_fail++; $display("FAIL err_one_cycle: got %b want 0", w_err); end
        n_checks++; if (w_cnt !== 8'h42) begin n_fail++; $display("FAIL hold42: got %h want 42", w_cnt); end
        w_load = 1'b1; w_val = 8'h60;
        step();
        n_checks++; if (w_cnt !== 8'h42) begin n_fail++; $display("FAIL over_limit_hold: got %h want 42", w_cnt); end
        n_checks++; if (w_err !== 1'b1) begin n_fail++; $display("FAIL over_limit_err: got %b want 1", w_err); end
        w_val = 8'h59;
        step();
        n_checks++; if (w_cnt !== 8'h59) begin n_fail++; $display("FAIL load_limit: got %h want 59", w_cnt); end
        n_checks++; if (w_err !== 1'b0) begin n_fail++; $display("FAIL load_limit_err: got %b want 0", w_err); end
        w_en = 1'b1; w_val = 8'h05;
        step();
        n_checks++; if (w_cnt !== 8'h05) begin n_fail++; $display("FAIL load_at_limit: got %h want 05", w_cnt); end
        n_checks++; if (w_ovf !== 1'b0) begin n_fail++; $display("FAIL load_no_ovf: got %b want 0", w_ovf); end
        w_load = 1'b0; w_en = 1'b0;
    endtask

    task automatic test_three_digit();
        t_up = 1'b1; t_load = 1'b1; t_val = 12'h099;
        step();
        t_load = 1'b0; t_en = 1'b1;
        step();
        n_checks++; if (t_cnt !== 12'h100) begin n_fail++; $display("FAIL d3_carry: got %h want 100", t_cnt); end
        t_load = 1'b1; t_val = 12'h999;
        step();
        t_load = 1'b0;
        n_checks++; if (t_tc !== 1'b1) begin n_fail++; $display("FAIL d3_tc: got %b want 1", t_tc); end
        step();
        n_checks++; if (t_cnt !== 12'h000) begin n_fail++; $display("FAIL d3_wrap: got %h want 000", t_cnt); end
        n_checks++; if (t_ovf !== 1'b1) begin n_fail++; $display("FAIL d3_wrap_ovf: got %b want 1", t_ovf); end
        t_up = 1'b0;
        step();
        n_checks++; if (t_cnt !== 12'h999) begin n_fail++; $display("FAIL d3_down_wrap: got %h want 999", t_cnt); end
        n_checks++; if (t_ovf !== 1'b1) begin n_fail++; $display("FAIL d3_down_ovf: got %b want 1", t_ovf); end
        step();
        n_checks++; if (t_cnt !== 12'h998) begin n_fail++; $display("FAIL d3_998: got %h want 998", t_cnt); end
        t_load = 1'b1; t_val = 12'h9A0;
        step();
        n_checks++; if (t_cnt !== 12'h998) begin n_fail++; $display("FAIL d3_bad_hold: got %h want 998", t_cnt); end
        n_checks++; if (t_err !== 1'b1) begin n_fail++; $display("FAIL d3_bad_err: got %b want 1", t_err); end
        t_val = 12'h500;
        step();
        t_load = 1'b0;
        step();
        n_checks++; if (t_cnt !== 12'h499) begin n_fail++; $display("FAIL d3_borrow: got %h want 499", t_cnt); end
        t_en = 1'b0;
    endtask

    task automatic test_cascade();
        c_up = 1'b1; c_load = 1'b1; c_sval = 8'h58; c_mval = 8'h07;
        step();
        c_load = 1'b0; c_en = 1'b1;
        step();
        n_checks++; if ({c_mcnt, c_scnt} !== 16'h0759) begin n_fail++; $display("FAIL casc_0759: got %h want 0759", {c_mcnt, c_scnt}); end
        step();
        n_checks++; if ({c_mcnt, c_scnt} !== 16'h0800) begin n_fail++; $display("FAIL casc_0800: got %h want 0800", {c_mcnt, c_scnt}); end
        n_checks++; if ({c_movf, c_sovf} !== 2'b01) begin n_fail++; $display("FAIL casc_ovf_sec: got %b want 01", {c_movf, c_sovf}); end
        c_en = 1'b0; c_load = 1'b1; c_sval = 8'h59; c_mval = 8'h59;
        step();
        c_load = 1'b0; c_en = 1'b1;
        #1;
        n_checks++; if ({c_mtc, c_stc} !== 2'b11) begin n_fail++; $display("FAIL casc_tc: got %b want 11", {c_mtc, c_stc}); end
        step();
        n_checks++; if ({c_mcnt, c_scnt} !== 16'h0000) begin n_fail++; $display("FAIL casc_wrap: got %h want 0000", {c_mcnt, c_scnt}); end
        n_checks++; if ({c_movf, c_sovf} !== 2'b11) begin n_fail++; $display("FAIL casc_wrap_ovf: got %b want 11", {c_movf, c_sovf}); end
        step();
        n_checks++; if ({c_mcnt, c_scnt} !== 16'h0001) begin n_fail++; $display("FAIL casc_0001: got %h want 0001", {c_mcnt, c_scnt}); end
        n_checks++; if (c_movf !== 1'b0) begin n_fail++; $display("FAIL casc_movf_clear: got %b want 0", c_movf); end
        c_en = 1'b0; c_load = 1'b1; c_sval = 8'h00; c_mval = 8'h00;
        step();
        c_load = 1'b0; c_up = 1'b0; c_en = 1'b1;
        step();
        n_checks++; if ({c_mcnt, c_scnt} !== 16'h5959) begin n_fail++; $display("FAIL casc_down: got %h want 5959", {c_mcnt, c_scnt}); end
        n_checks++; if ({c_movf, c_sovf} !== 2'b11) begin n_fail++; $display("FAIL casc_down_ovf: got %b want 11", {c_movf, c_sovf}); end
        c_en = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        {w_en, w_up, w_load} = '0; w_val = '0;
        {s_en, s_up, s_load} = '0; s_val = '0;
        {t_en, t_up, t_load} = '0; t_val = '0;
        {c_en, c_up, c_load} = '0; c_sval = '0; c_mval = '0;
        test_reset();
        test_reset_mid_count();
        test_carry_wrap();
        test_down_borrow();
        test_saturate();
        test_load();
        test_three_digit();
        test_cascade();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_updn_cnt.md
# bcd_updn_cnt

Parametrised multi-digit BCD up/down counter with a programmable terminal value, synchronous load and a wrap/saturate mode. It generalises the single-digit cascaded BCD up-counter into one block. It is the building block for the lab timers, stopwatches and clock displays: a minutes/seconds field is one instance with LIMIT=8'h59. Its output drives the seven-segment digit mux directly.

## Interface

- DIGITS, 2, number of BCD digits (1–8); count width is 4*DIGITS bits
- LIMIT, all-nines (8'h99 for DIGITS=2), terminal value in BCD, every digit ≤ 9
- SATURATE, 0, 0 = wrap at the ends, 1 = hold at the ends
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- en  in  1  count enable, one step per cycle while high
- up  in  1  direction: 1 = increment, 0 = decrement; sampled only when en=1
- load  in  1  synchronous load strobe
- load_val  in  4*DIGITS  BCD value to load
- cnt  out  4*DIGITS  current count, BCD, digit 0 in bits [3:0]
- tc  out  1  terminal count, combinational: (up && cnt==LIMIT) || (!up && cnt==0)
- ovf  out  1  registered one-cycle pulse on a wrap event
- load_err  out  1  registered one-cycle pulse when a load is rejected

## Operation

- Reset (rst=0, any time, including mid-count): cnt=0, ovf=0, load_err=0 immediately. tc then follows its equation.
- Priority each cycle: load > en > hold.
- **Load**
  - Valid when every nibble of load_val is ≤ 9 and load_val ≤ LIMIT, compared as a BCD/decimal value.
  - Valid load: cnt←load_val, load_err=0.
  - Invalid load: cnt holds, load_err=1 for that cycle.
  - ovf=0 on any load cycle. en is ignored during load.
- **Count up** (en=1, up=1)
  - cnt<LIMIT: decimal increment. Digit 0 increments; a digit at 9 goes to 0 and carries into the next digit. The carry ripples within the same cycle and there is no intermediate state.
  - cnt==LIMIT, SATURATE=0: cnt←0, ovf=1.
  - cnt==LIMIT, SATURATE=1: cnt holds, ovf=0.
- **Count down** (en=1, up=0)
  - cnt>0: decimal decrement. A digit at 0 goes to 9 and borrows from the next digit.
  - cnt==0, SATURATE=0: cnt←LIMIT, ovf=1.
  - cnt==0, SATURATE=1: cnt holds, ovf=0.
- Hold (en=0, load=0): cnt unchanged, ovf=0, load_err=0.
- The LIMIT comparison is a full-width equality on the BCD vector. Intermediate values never exceed LIMIT because the wrap is taken at equality, not at overflow.
- No binary arithmetic is permitted on the full vector. Each digit uses its own 4-bit increment/decrement plus a carry/borrow chain, so no nibble ever leaves the range 0–9.
- Cascading instances:
  - Drive the higher instance's en with the lower instance's (en && tc).
  - Use the same up on both instances.
  - tc is combinational, so this forms a same-cycle chain.

## Timing

- Single clock domain. All state changes on the rising clk edge, except the asynchronous reset assertion.
- Count, load and wrap latency: 1 cycle. cnt shows the new value after the edge at which en or load was sampled high.
- ovf and load_err are high for exactly the cycle following the triggering edge. They are never high together.
- tc is combinational from cnt and up, with no register. A change of up changes tc in the same cycle.
- Reset deassertion is synchronised externally. The first enabled edge after release increments from 0.

## Test plan

- Reset mid-count: DIGITS=2, count to 8'h37, assert rst between edges → cnt=8'h00, ovf=0 immediately; after release, one en cycle → 8'h01.
- Decimal carry and wrap: DIGITS=2, LIMIT=8'h59, SATURATE=0, up=1, en=1 from 8'h58.
  - Required sequence: 8'h59 (tc=1), then 8'h00 with ovf=1 for one cycle, then 8'h01.
  - Across 8'h09 the next value is 8'h10. The values 8'h0A–8'h0F never appear.
- Down-count borrow and wrap: same config, up=0, from 8'h10.
  - Required sequence: 8'h09, …, 8'h00 (tc=1), then 8'h59 with ovf=1.
- Saturate: SATURATE=1, up=1 at cnt=LIMIT → cnt stays at LIMIT, ovf=0. up=0 at 0 → cnt stays at 0.
- Load priority and rejection: load=1 and en=1 with load_val=8'h42 → cnt=8'h42, no increment.
  - load_val=8'h4A → load_err pulse, cnt unchanged.
  - load_val=8'h60 with LIMIT=8'h59 → load_err pulse, cnt unchanged.
- Cascade: two instances (seconds LIMIT=8'h59, minutes LIMIT=8'h59), minutes en = sec.en && sec.tc.
  - From 59:59 with en=1 → 00:00 after one edge, ovf=1 on both instances.
